dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Two-port arbiter sharing the single-write, single-read 16x32 data memory between requester 0 (CPU load/store unit) and requester 1 (debug/DMA port).
- Grants at most one access per cycle. Uses round-robin priority with an optional bounded lock for short bursts.
- Drives the memory's write and read ports directly. Registers read data back to the winning requester.

Parameters:
- ADDR_W, 4, memory address width (16 entries).
- DATA_W, 32, data width.
- MAX_HOLD, 8, maximum consecutive locked grants before ownership is forcibly released (range 1..255).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req0  in  1  requester 0 access request
- we0  in  1  requester 0 write (1) / read (0)
- lock0  in  1  requester 0 asks to retain ownership after this grant
- addr0  in  ADDR_W  requester 0 address
- wdata0  in  DATA_W  requester 0 write data
- gnt0  out  1  requester 0 access accepted this cycle (combinational)
- rvalid0  out  1  read data valid for requester 0
- rdata0  out  DATA_W  read data for requester 0
- req1, we1, lock1, addr1, wdata1, gnt1, rvalid1, rdata1: same as requester 0, for requester 1
- mem_wr_en  out  1  memory write enable
- mem_wr_addr  out  ADDR_W  memory write address
- mem_wr_data  out  DATA_W  memory write data
- mem_rd_addr  out  ADDR_W  memory read address
- mem_rd_data  in  DATA_W  memory asynchronous read data

Behaviour:
- Handshake: a request is accepted in a cycle where reqN=1 and gntN=1.
  - The requester holds we/addr/wdata stable while reqN=1 and gntN=0.
  - Ungranted requests are never dropped; they stay pending until granted.
- Writes: in the grant cycle, mem_wr_en=weN and mem_wr_addr/mem_wr_data come from the winner. The memory commits at that posedge.
- Reads: in the grant cycle, mem_rd_addr=addrN. At the posedge, rdataN<=mem_rd_data and rvalidN<=1. Latency is 1 cycle.
  - rvalidN is a 1-cycle pulse per granted read.
  - rdataN holds its value until the next granted read.
- No grant: mem_wr_en=0 and mem_rd_addr=0.
- Read-after-write: a write granted in cycle N followed by a read granted in cycle N+1 returns the new data.
- FSM states: FREE, OWN0, OWN1.
  - FREE: round-robin.
    - Only one requester requesting: it is granted.
    - Both requesting: grant the requester not in last_gnt.
    - last_gnt updates on every grant.
  - FREE -> OWNn: on a grant to n with lockN=1; hold_cnt<=1.
  - OWNn with reqN=1: grant n, regardless of the other requester.
    - If lockN=1 and hold_cnt<MAX_HOLD-1: stay in OWNn and increment hold_cnt.
    - Otherwise: return to FREE and set last_gnt=n, so the other requester wins the next conflict.
  - OWNn with reqN=0: return to FREE in the same cycle and arbitrate as FREE. The other requester may be granted in that cycle.
  - MAX_HOLD bounds any owner to MAX_HOLD consecutive grants.
- Reset values:
  - State FREE.
  - last_gnt=1, so requester 0 wins the first conflict.
  - hold_cnt=0.
  - rvalid0/1=0, rdata0/1=0.
  - gnt0/1 and mem_wr_en are forced to 0 while rst=1.
- Reset mid-operation: a pending read's rvalid is suppressed. Lock ownership is lost. No memory write occurs in a cycle with rst=1.
- gnt0 and gnt1 are never both 1 (mutually exclusive).

Optional Feature:
- Macro DMEM_ARB_STATS_EN.
- Defined:
  - Adds outputs stat_gnt0, stat_gnt1 (16 bits each): saturating counts of grants.
  - Adds output stat_conflict (16 bits): saturating count of cycles with both reqs high.
  - All three clear on rst.
- Undefined: these ports and their logic are absent. Arbitration behaviour is identical in both cases.

Test Plan:
- Reset, then req0 write addr 3 = 0xDEADBEEF, next cycle req0 read addr 3 -> gnt0 both cycles; rvalid0 the cycle after the read grant; rdata0=0xDEADBEEF.
- req0 and req1 both held high, lock=0, for 4 cycles -> grants alternate 0,1,0,1. The first conflict after reset goes to 0.
- req0 with lock0=1 and req1 high for 12 cycles, MAX_HOLD=8 -> gnt0 for cycles 1-8, gnt1 in cycle 9, then alternating.
- Owner in OWN1 drops req1 while req0 pending -> gnt0 in the same cycle; state FREE.
- Same-cycle conflict: req1 write addr 5 = 0x1234 wins, req0 read addr 5 granted next cycle -> rdata0=0x1234; rvalid1 never pulses.
- Assert rst in the cycle a read is granted -> no rvalid the next cycle; gnt0/gnt1=0 during reset. With DMEM_ARB_STATS_EN, all counters read 0 after reset.

Source files
------------

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter
// Description : Round-robin arbiter with bounded lock that shares a 16x32 data
//               memory between requester 0 (LSU) and requester 1 (debug/DMA).
//               Optional grant/conflict statistics: DMEM_ARB_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
    parameter int ADDR_W   = 4,
    parameter int DATA_W   = 32,
    parameter int MAX_HOLD = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              we0,
    input  logic              lock0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              gnt0,
    output logic              rvalid0,
    output logic [DATA_W-1:0] rdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic              lock1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt1,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata1,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_wr_addr,
    output logic [DATA_W-1:0] mem_wr_data,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [DATA_W-1:0] mem_rd_data
`ifdef DMEM_ARB_STATS_EN
   ,output logic [15:0]       stat_gnt0,
    output logic [15:0]       stat_gnt1,
    output logic [15:0]       stat_conflict
`endif
);

    localparam logic [1:0] c_FREE = 2'd0;
    localparam logic [1:0] c_OWN0 = 2'd1;
    localparam logic [1:0] c_OWN1 = 2'd2;

    // Owner may keep going while hold count is below this value.
    localparam logic [7:0] c_HOLD_LIMIT = 8'(MAX_HOLD - 1);
    // With MAX_HOLD=1 a lock can never extend ownership, so never enter OWNn.
    localparam logic       c_CAN_LOCK   = (MAX_HOLD > 1);

    logic [1:0] r_state;
    logic       r_last_gnt;
    logic [7:0] r_hold_cnt;

    logic [1:0] w_state_nxt;
    logic       w_last_nxt;
    logic [7:0] w_hold_nxt;
    logic       w_free_arb;
    logic       w_gnt0;
    logic       w_gnt1;

    always_comb begin
        w_gnt0      = 1'b0;
        w_gnt1      = 1'b0;
        w_state_nxt = r_state;
        w_last_nxt  = r_last_gnt;
        w_hold_nxt  = r_hold_cnt;
        w_free_arb  = 1'b1;

        case (r_state)
            c_OWN0: begin
                if (req0) begin
                    w_free_arb = 1'b0;
                    w_gnt0     = 1'b1;
                    if (lock0 && (r_hold_cnt < c_HOLD_LIMIT)) begin
                        w_hold_nxt = r_hold_cnt + 8'd1;
                    end else begin
                        w_state_nxt = c_FREE;
                        w_last_nxt  = 1'b0;
                        w_hold_nxt  = 8'd0;
                    end
                end
            end
            c_OWN1: begin
                if (req1) begin
                    w_free_arb = 1'b0;
                    w_gnt1     = 1'b1;
                    if (lock1 && (r_hold_cnt < c_HOLD_LIMIT)) begin
                        w_hold_nxt = r_hold_cnt + 8'd1;
                    end else begin
                        w_state_nxt = c_FREE;
                        w_last_nxt  = 1'b1;
                        w_hold_nxt  = 8'd0;
                    end
                end
            end
            default: ;
        endcase

        // An owner that stops requesting falls through to round-robin this cycle.
        if (w_free_arb) begin
            w_state_nxt = c_FREE;
            w_hold_nxt  = 8'd0;
            if (req0 && (!req1 || r_last_gnt)) begin
                w_gnt0     = 1'b1;
                w_last_nxt = 1'b0;
                if (lock0 && c_CAN_LOCK) begin
                    w_state_nxt = c_OWN0;
                    w_hold_nxt  = 8'd1;
                end
            end else if (req1) begin
                w_gnt1     = 1'b1;
                w_last_nxt = 1'b1;
                if (lock1 && c_CAN_LOCK) begin
                    w_state_nxt = c_OWN1;
                    w_hold_nxt  = 8'd1;
                end
            end
        end

        if (rst) begin
            w_gnt0 = 1'b0;
            w_gnt1 = 1'b0;
        end
    end

    assign gnt0        = w_gnt0;
    assign gnt1        = w_gnt1;
    assign mem_wr_en   = (w_gnt0 & we0) | (w_gnt1 & we1);
    assign mem_wr_addr = w_gnt1 ? addr1  : addr0;
    assign mem_wr_data = w_gnt1 ? wdata1 : wdata0;
    assign mem_rd_addr = w_gnt0 ? addr0 : (w_gnt1 ? addr1 : '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_FREE;
            r_last_gnt <= 1'b1;
            r_hold_cnt <= 8'd0;
            rvalid0    <= 1'b0;
            rvalid1    <= 1'b0;
            rdata0     <= '0;
            rdata1     <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_last_gnt <= w_last_nxt;
            r_hold_cnt <= w_hold_nxt;
            rvalid0    <= w_gnt0 & ~we0;
            rvalid1    <= w_gnt1 & ~we1;
            if (w_gnt0 && !we0) begin
                rdata0 <= mem_rd_data;
            end
            if (w_gnt1 && !we1) begin
                rdata1 <= mem_rd_data;
            end
        end
    end

`ifdef DMEM_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_gnt0     <= 16'd0;
            stat_gnt1     <= 16'd0;
            stat_conflict <= 16'd0;
        end else begin
            if (w_gnt0 && (stat_gnt0 != 16'hFFFF)) begin
                stat_gnt0 <= stat_gnt0 + 16'd1;
            end
            if (w_gnt1 && (stat_gnt1 != 16'hFFFF)) begin
                stat_gnt1 <= stat_gnt1 + 16'd1;
            end
            if (req0 && req1 && (stat_conflict != 16'hFFFF)) begin
                stat_conflict <= stat_conflict + 16'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_arbiter
// Description : Scoreboard bench for dmem_arbiter with a behavioural 16x32
//               memory (async read, sync write).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

    logic        clk;
    logic        rst;
    logic        req0, we0, lock0, req1, we1, lock1;
    logic [3:0]  addr0, addr1;
    logic [31:0] wdata0, wdata1;
    logic        gnt0, gnt1, rvalid0, rvalid1;
    logic [31:0] rdata0, rdata1;
    logic        mem_wr_en;
    logic [3:0]  mem_wr_addr, mem_rd_addr;
    logic [31:0] mem_wr_data, mem_rd_data;
`ifdef DMEM_ARB_STATS_EN
    logic [15:0] stat_gnt0, stat_gnt1, stat_conflict;
`endif

    logic [31:0] mem [16];
    logic [1:0]  gq [$];
    logic [32:0] rdq [$];
    logic [1:0]  m_eg;
    logic [32:0] m_er;
    int          n_tests;
    int          n_fail;

    dmem_arbiter #(.ADDR_W(4), .DATA_W(32), .MAX_HOLD(8)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .we0(we0), .lock0(lock0), .addr0(addr0), .wdata0(wdata0),
        .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
        .req1(req1), .we1(we1), .lock1(lock1), .addr1(addr1), .wdata1(wdata1),
        .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
        .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
        .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data)
`ifdef DMEM_ARB_STATS_EN
       ,.stat_gnt0(stat_gnt0), .stat_gnt1(stat_gnt1), .stat_conflict(stat_conflict)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rd_data = mem[mem_rd_addr];
    always @(posedge clk) begin
        if (mem_wr_en) mem[mem_wr_addr] <= mem_wr_data;
    end

    // Monitor: grant pattern every stimulated cycle, read data on every rvalid.
    always @(negedge clk) begin
        if (gq.size() > 0) begin
            m_eg = gq.pop_front();
            n_tests++;
            if ({gnt1, gnt0} !== m_eg) begin
                n_fail++;
                $display("FAIL gnt @%0t: got %b expected %b", $time, {gnt1, gnt0}, m_eg);
            end
        end
        if (rvalid0 || rvalid1) begin
            n_tests++;
            if (rdq.size() == 0) begin
                n_fail++;
                $display("FAIL rvalid_unexpected @%0t: got rvalid1/0=%b%b expected none",
                         $time, rvalid1, rvalid0);
            end else begin
                m_er = rdq.pop_front();
                if ((rvalid0 && rvalid1) ||
                    ({rvalid1, rvalid1 ? rdata1 : rdata0} !== m_er)) begin
                    n_fail++;
                    $display("FAIL rdata @%0t: got port%0d data %h expected port%0d data %h",
                             $time, rvalid1, rvalid1 ? rdata1 : rdata0, m_er[32], m_er[31:0]);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Drive one cycle (bit0 = requester 0, bit1 = requester 1) and queue its grant.
    task automatic step(input logic rs, input logic [1:0] rq, input logic [1:0] we,
                        input logic [1:0] lk, input logic [3:0] a0, input logic [3:0] a1,
                        input logic [31:0] d0, input logic [31:0] d1, input logic [1:0] eg);
        @(posedge clk); #1;
        rst = rs;
        req0 = rq[0]; we0 = we[0]; lock0 = lk[0]; addr0 = a0; wdata0 = d0;
        req1 = rq[1]; we1 = we[1]; lock1 = lk[1]; addr1 = a1; wdata1 = d1;
        gq.push_back(eg);
    endtask

    task automatic exp_rd(input logic port, input logic [31:0] d);
        rdq.push_back({port, d});
    endtask

    task automatic do_reset();
        step(1'b1, 2'b00, 2'b00, 2'b00, 4'd0, 4'd0, 32'd0, 32'd0, 2'b00);
        step(1'b1, 2'b00, 2'b00, 2'b00, 4'd0, 4'd0, 32'd0, 32'd0, 2'b00);
    endtask

    task automatic idle();
        step(1'b0, 2'b00, 2'b00, 2'b00, 4'd0, 4'd0, 32'd0, 32'd0, 2'b00);
    endtask

    initial begin
        n_tests = 0; n_fail = 0;
        rst = 1'b1;
        req0 = 0; we0 = 0; lock0 = 0; addr0 = 0; wdata0 = 0;
        req1 = 0; we1 = 0; lock1 = 0; addr1 = 0; wdata1 = 0;

        // Reset with both requesters active: no grant may appear.
        step(1'b1, 2'b11, 2'b11, 2'b00, 4'd1, 4'd2, 32'h1, 32'h2, 2'b00);
        do_reset();
        chk("reset_rvalid0", {31'd0, rvalid0}, 32'd0);
        chk("reset_rvalid1", {31'd0, rvalid1}, 32'd0);
        chk("reset_rdata0", rdata0, 32'd0);
        chk("reset_rdata1", rdata1, 32'd0);

        // Write then read-after-write from requester 0.
        step(1'b0, 2'b01, 2'b01, 2'b00, 4'd3, 4'd0, 32'hDEADBEEF, 32'd0, 2'b01);
        step(1'b0, 2'b01, 2'b00, 2'b00, 4'd3, 4'd0, 32'd0, 32'd0, 2'b01);
        exp_rd(1'b0, 32'hDEADBEEF);
        idle();
`ifdef DMEM_ARB_STATS_EN
        chk("stat_gnt0_count", {16'd0, stat_gnt0}, 32'd2);
        chk("stat_gnt1_count", {16'd0, stat_gnt1}, 32'd0);
`endif

        // Round-robin with both requesting; first conflict after reset goes to 0.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 2'b11, 2'b01, 2'b00, 4'd7, 4'd3, 32'h11, 32'd0,
                 (i % 2 == 0) ? 2'b01 : 2'b10);
            if (i % 2 == 1) exp_rd(1'b1, 32'hDEADBEEF);
        end
        idle();

        // Bounded lock: 8 grants to 0, then 1, then plain alternation.
        do_reset();
        for (int i = 1; i <= 12; i++) begin
            step(1'b0, 2'b11, 2'b11, {1'b0, (i <= 9)}, 4'd9, 4'd10, i, 32'h22,
                 (i <= 8) ? 2'b01 : (i == 9) ? 2'b10 : (i % 2 == 0) ? 2'b01 : 2'b10);
        end
        idle();

        // OWN1 owner drops its request: requester 0 granted the same cycle, then FREE.
        do_reset();
        step(1'b0, 2'b10, 2'b11, 2'b10, 4'd12, 4'd11, 32'h31, 32'h41, 2'b10);
        step(1'b0, 2'b11, 2'b11, 2'b10, 4'd12, 4'd11, 32'h32, 32'h42, 2'b10);
        step(1'b0, 2'b01, 2'b11, 2'b00, 4'd12, 4'd11, 32'h33, 32'h43, 2'b01);
        step(1'b0, 2'b11, 2'b11, 2'b00, 4'd12, 4'd11, 32'h34, 32'h44, 2'b10);
        step(1'b0, 2'b11, 2'b11, 2'b00, 4'd12, 4'd11, 32'h35, 32'h45, 2'b01);

        // Conflict: requester 1 write wins, requester 0 read of same address next.
        step(1'b0, 2'b11, 2'b10, 2'b00, 4'd5, 4'd5, 32'd0, 32'h1234, 2'b10);
        step(1'b0, 2'b01, 2'b00, 2'b00, 4'd5, 4'd0, 32'd0, 32'd0, 2'b01);
        exp_rd(1'b0, 32'h1234);
        idle();

        // Reset while a read and a write are requested: no grant, no rvalid, no write.
        step(1'b1, 2'b11, 2'b10, 2'b11, 4'd3, 4'd3, 32'd0, 32'hBAD0BAD0, 2'b00);
        step(1'b1, 2'b00, 2'b00, 2'b00, 4'd0, 4'd0, 32'd0, 32'd0, 2'b00);
        chk("mid_reset_rdata0", rdata0, 32'd0);
        chk("mid_reset_rvalid0", {31'd0, rvalid0}, 32'd0);
`ifdef DMEM_ARB_STATS_EN
        chk("stat_gnt0_reset", {16'd0, stat_gnt0}, 32'd0);
        chk("stat_gnt1_reset", {16'd0, stat_gnt1}, 32'd0);
        chk("stat_conflict_reset", {16'd0, stat_conflict}, 32'd0);
`endif
        step(1'b0, 2'b01, 2'b00, 2'b00, 4'd3, 4'd0, 32'd0, 32'd0, 2'b01);
        exp_rd(1'b0, 32'hDEADBEEF);
        idle();
        idle();
        @(negedge clk); #1;

        chk("rd_queue_drained", rdq.size(), 32'd0);
        chk("gnt_queue_drained", gq.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
